// File: rtl/sprite_palette_bank.sv
// Runtime-writable sprite palette bank with a 2-cycle lookup pipeline and a fade engine.
// Optional transparent-key flag on index 0 is enabled by SPRITE_PALETTE_TRANSPARENT_KEY_EN.
module sprite_palette_bank #(
    parameter int INDEX_W  = 4,
    parameter int CHAN_W   = 4,
    parameter int NUM_PAL  = 4,
    parameter int FADE_DIV = 4,
    localparam int PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pix_valid,
    input  logic [PAL_W-1:0]      pix_pal,
    input  logic [INDEX_W-1:0]    pix_index,
    output logic                  out_valid,
    output logic [CHAN_W-1:0]     red,
    output logic [CHAN_W-1:0]     green,
    output logic [CHAN_W-1:0]     blue,
    output logic                  out_transparent,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PAL_W-1:0]      wr_pal,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [3*CHAN_W-1:0]   wr_rgb,
    input  logic                  fade_start,
    input  logic                  fade_dir,
    output logic                  fade_busy,
    output logic [CHAN_W-1:0]     fade_level
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [CHAN_W-1:0] LMAX     = '1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PAL_W:0]    PAL_LIM  = NUM_PAL[PAL_W:0];

    typedef enum logic [1:0] {IDLE = 2'd0, FADE_OUT = 2'd1, FADE_IN = 2'd2} fade_state_t;

    function automatic logic [CHAN_W-1:0] fade_chan(input logic [CHAN_W-1:0] c,
                                                     input logic [CHAN_W-1:0] dim);
        logic [CHAN_W:0] diff;
        diff = {1'b0, c} - {1'b0, dim};
        return diff[CHAN_W] ? {CHAN_W{1'b0}} : diff[CHAN_W-1:0];
    endfunction

    logic [3*CHAN_W-1:0] mem_r [NUM_PAL][ENTRIES];
    fade_state_t         state_r, state_s;
    logic [CHAN_W-1:0]   level_r, level_s;
    logic [DIV_W-1:0]    div_r, div_s;
    logic                s1_valid_r;
    logic [3*CHAN_W-1:0] s1_rgb_r;
    logic [PAL_W-1:0]    rd_pal_s;
    logic                wr_en_s;
    logic [CHAN_W-1:0]   dim_s;

    assign fade_busy  = (state_r != IDLE);
    assign wr_ready   = ~fade_busy;
    assign fade_level = level_r;
    assign wr_en_s    = wr_valid & wr_ready & ({1'b0, wr_pal} < PAL_LIM);
    assign rd_pal_s   = ({1'b0, pix_pal} < PAL_LIM) ? pix_pal : {PAL_W{1'b0}};
    assign dim_s      = LMAX - level_r;

    // Palette storage; reads in the same cycle see the pre-write contents.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    mem_r[p][e] <= '0;
                end
            end
        end else if (wr_en_s) begin
            mem_r[wr_pal][wr_index] <= wr_rgb;
        end
    end

    // Stage 1: capture entry and request valid.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_r <= 1'b0;
            s1_rgb_r   <= '0;
        end else begin
            s1_valid_r <= pix_valid;
            s1_rgb_r   <= mem_r[rd_pal_s][pix_index];
        end
    end

    // Stage 2: apply fade; RGB holds when no valid lookup arrives.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                red   <= fade_chan(s1_rgb_r[3*CHAN_W-1:2*CHAN_W], dim_s);
                green <= fade_chan(s1_rgb_r[2*CHAN_W-1:CHAN_W], dim_s);
                blue  <= fade_chan(s1_rgb_r[CHAN_W-1:0], dim_s);
            end
        end
    end

`ifdef SPRITE_PALETTE_TRANSPARENT_KEY_EN
    logic s1_zero_r;

    // Transparent key tracks index 0 through the pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_zero_r       <= 1'b0;
            out_transparent <= 1'b0;
        end else begin
            s1_zero_r       <= (pix_index == {INDEX_W{1'b0}});
            out_transparent <= s1_valid_r & s1_zero_r;
        end
    end
`else
    assign out_transparent = 1'b0;
`endif

    // Fade state, level and divider registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            level_r <= LMAX;
            div_r   <= '0;
        end else begin
            state_r <= state_s;
            level_r <= level_s;
            div_r   <= div_s;
        end
    end

    // Fade next-state: a step every FADE_DIV cycles, exit on the edge the target is hit.
    always_comb begin
        state_s = state_r;
        level_s = level_r;
        div_s   = div_r;
        case (state_r)
            IDLE: begin
                if (fade_start) begin
                    state_s = fade_dir ? FADE_IN : FADE_OUT;
                    div_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            FADE_OUT: begin
                if (level_r == {CHAN_W{1'b0}}) begin
                    state_s = IDLE;
                end else if (div_r == DIV_LAST) begin
                    div_s   = '0;
                    level_s = level_r - {{(CHAN_W-1){1'b0}}, 1'b1};
                    state_s = (level_r == {{(CHAN_W-1){1'b0}}, 1'b1}) ? IDLE : FADE_OUT;
                end else begin
                    div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            FADE_IN: begin
                if (level_r == LMAX) begin
                    state_s = IDLE;
                end else if (div_r == DIV_LAST) begin
                    div_s   = '0;
                    level_s = level_r + {{(CHAN_W-1){1'b0}}, 1'b1};
                    state_s = (level_r == LMAX - {{(CHAN_W-1){1'b0}}, 1'b1}) ? IDLE : FADE_IN;
                end else begin
                    div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                div_s   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed self-checking bench for sprite_palette_bank (FADE_DIV=2, other parameters default).
module tb_sprite_palette_bank;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [1:0]  pix_pal;
    logic [3:0]  pix_index;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        out_transparent;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_pal;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        fade_start;
    logic        fade_dir;
    logic        fade_busy;
    logic [3:0]  fade_level;

    int checks_r   = 0;
    int failures_r = 0;
    int busy_cnt;

    sprite_palette_bank #(.INDEX_W(4), .CHAN_W(4), .NUM_PAL(4), .FADE_DIV(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid(pix_valid), .pix_pal(pix_pal), .pix_index(pix_index),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .out_transparent(out_transparent),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal),
        .wr_index(wr_index), .wr_rgb(wr_rgb),
        .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_busy(fade_busy), .fade_level(fade_level)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [1:0] pal, input logic [3:0] idx);
        pix_valid = 1'b1;
        pix_pal   = pal;
        pix_index = idx;
    endtask

    task automatic write_entry(input logic [1:0] pal, input logic [3:0] idx, input logic [11:0] rgb);
        wr_valid = 1'b1;
        wr_pal   = pal;
        wr_index = idx;
        wr_rgb   = rgb;
    endtask

    // Single lookup: drive, wait two edges, compare RGB.
    task automatic lookup_check(input string tag, input logic [1:0] pal, input logic [3:0] idx,
                                input logic [11:0] exp);
        @(negedge Clk);
        lookup(pal, idx);
        @(negedge Clk);
        pix_valid = 1'b0;
        @(negedge Clk);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp));
    endtask

    // Fade run: count busy cycles after the start edge, bounded.
    task automatic run_fade(input logic dir, output int cnt);
        @(negedge Clk);
        fade_start = 1'b1;
        fade_dir   = dir;
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            fade_start = 1'b0;
            if (!fade_busy) break;
            cnt++;
        end
    endtask

    initial begin
        Reset_n = 1'b0; pix_valid = 1'b0; pix_pal = 2'd0; pix_index = 4'd0;
        wr_valid = 1'b0; wr_pal = 2'd0; wr_index = 4'd0; wr_rgb = 12'h000;
        fade_start = 1'b0; fade_dir = 1'b0;
        repeat (3) @(negedge Clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_rgb", 32'({red, green, blue}), 32'h000);
        check_val("rst_level", 32'(fade_level), 32'd15);
        check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_val("rst_busy", 32'(fade_busy), 32'd0);
        check_val("rst_transp", 32'(out_transparent), 32'd0);
        Reset_n = 1'b1;

        // Cleared storage, with the stage-1-only cycle checked as not yet valid.
        @(negedge Clk);
        lookup(2'd2, 4'd5);
        @(negedge Clk);
        pix_valid = 1'b0;
        check_val("lat1_not_valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        check_val("lat2_valid", 32'(out_valid), 32'd1);
        check_val("p2i5_rgb", 32'({red, green, blue}), 32'h000);

        @(negedge Clk);
        write_entry(2'd1, 4'd3, 12'hB74);
        @(negedge Clk);
        wr_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            check_val("b2b_valid", 32'(out_valid), 32'((j >= 2) && (j <= 5)));
            if (j >= 2 && j <= 5) check_val("b2b_rgb", 32'({red, green, blue}), 32'hB74);
            if (j < 4) lookup(2'd1, 4'd3);
            else pix_valid = 1'b0;
            @(negedge Clk);
        end

        // Same-cycle write and lookup returns the old entry.
        write_entry(2'd0, 4'd7, 12'hFFF);
        lookup(2'd0, 4'd7);
        @(negedge Clk);
        wr_valid = 1'b0;
        @(negedge Clk);
        pix_valid = 1'b0;
        check_val("rw_old_rgb", 32'({red, green, blue}), 32'h000);
        @(negedge Clk);
        check_val("rw_new_rgb", 32'({red, green, blue}), 32'hFFF);

        @(negedge Clk);
        write_entry(2'd3, 4'd9, 12'hE94);
        @(negedge Clk);
        wr_valid = 1'b0;
        fade_start = 1'b1;
        fade_dir   = 1'b0;
        busy_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (n == 0) fade_start = 1'b0;
            if (!fade_busy) break;
            busy_cnt++;
            if (n == 3) begin
                check_val("fade_wr_ready", 32'(wr_ready), 32'd0);
                write_entry(2'd3, 4'd9, 12'h123);
            end
            if (n == 4) wr_valid = 1'b0;
            if (n == 5) begin
                fade_start = 1'b1;
                fade_dir   = 1'b1;
            end
            if (n == 6) fade_start = 1'b0;
            if (n == 7) lookup(2'd3, 4'd9);
            if (n == 8) pix_valid = 1'b0;
            if (n == 9) begin
                check_val("fade_lvl11", 32'(fade_level), 32'd11);
                check_val("fade_rgb_a50", 32'({red, green, blue}), 32'hA50);
            end
        end
        check_val("fade_out_busy_cycles", 32'(busy_cnt), 32'd30);
        check_val("fade_out_level", 32'(fade_level), 32'd0);
        lookup_check("black", 2'd3, 4'd9, 12'h000);

        run_fade(1'b1, busy_cnt);
        check_val("fade_in_busy_cycles", 32'(busy_cnt), 32'd30);
        check_val("fade_in_level", 32'(fade_level), 32'd15);
        lookup_check("kept_entry", 2'd3, 4'd9, 12'hE94);

        run_fade(1'b1, busy_cnt);
        check_val("at_target_busy", 32'(busy_cnt), 32'd1);
        check_val("at_target_level", 32'(fade_level), 32'd15);

        // Transparent key on index 0, then reset while a result is in flight.
        @(negedge Clk);
        lookup(2'd0, 4'd0);
        @(negedge Clk);
        lookup(2'd0, 4'd1);
        @(negedge Clk);
        pix_valid = 1'b0;
`ifdef SPRITE_PALETTE_TRANSPARENT_KEY_EN
        check_val("transp_idx0", 32'({out_valid, out_transparent}), 32'h3);
`else
        check_val("transp_idx0", 32'({out_valid, out_transparent}), 32'h2);
`endif
        @(negedge Clk);
        check_val("transp_idx1", 32'({out_valid, out_transparent}), 32'h2);

        lookup(2'd1, 4'd3);
        @(negedge Clk);
        @(negedge Clk);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        Reset_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_rgb", 32'({red, green, blue}), 32'h000);
        pix_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_val("post_rst_valid", 32'(out_valid), 32'd0);
        lookup_check("post_rst_cleared", 2'd1, 4'd3, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Parametrised, runtime-writable successor to the fixed per-sprite 16-colour palette ROMs.
- Holds NUM_PAL palettes of 2^INDEX_W RGB entries. Software or a loader writes entries through a ready/valid port.
- Converts a sprite pixel index plus palette select into registered RGB with 2-cycle latency.
- A built-in fade engine darkens or restores all output colour for screen transitions. The block sits between the sprite/background pixel mux and the VGA colour output stage.

Parameters:
- INDEX_W, 4, pixel index width; each palette has 2^INDEX_W entries.
- CHAN_W, 4, bits per colour channel; LMAX = 2^CHAN_W-1.
- NUM_PAL, 4, number of palettes; PAL_W = max(1, clog2(NUM_PAL)).
- FADE_DIV, 4, clock cycles per fade level step (≥1).

Ports:
- Clk, in, 1, system clock; all logic on rising edge.
- Reset_n, in, 1, asynchronous active-low reset.
- pix_valid, in, 1, lookup request this cycle.
- pix_pal, in, PAL_W, palette select.
- pix_index, in, INDEX_W, colour index.
- out_valid, out, 1, RGB valid (pix_valid delayed by 2).
- red, out, CHAN_W, output red channel.
- green, out, CHAN_W, output green channel.
- blue, out, CHAN_W, output blue channel.
- out_transparent, out, 1, transparent flag (see Optional Feature).
- wr_valid, in, 1, palette write request.
- wr_ready, out, 1, write accepted when wr_valid&wr_ready.
- wr_pal, in, PAL_W, palette to write.
- wr_index, in, INDEX_W, entry to write.
- wr_rgb, in, 3*CHAN_W, {r,g,b} entry data.
- fade_start, in, 1, one-cycle fade request.
- fade_dir, in, 1, fade direction: 0 = fade out (toward black), 1 = fade in.
- fade_busy, out, 1, fade in progress.
- fade_level, out, CHAN_W, current brightness level.

Behaviour:
- Reset (async assert, sync deassert by design):
  - All palette entries = 0.
  - level = LMAX, FSM = IDLE, divider = 0.
  - out_valid = 0; red/green/blue = 0; out_transparent = 0.
  - fade_busy = 0; wr_ready = 1.
  - Reset mid-fade or mid-pipeline discards everything.
- Storage: NUM_PAL × 2^INDEX_W registers of 3*CHAN_W bits. pix_pal ≥ NUM_PAL reads palette 0; a write with wr_pal ≥ NUM_PAL is accepted and dropped.
- Write port:
  - wr_ready = ~fade_busy.
  - On accepted write the entry updates at the clock edge.
- Pipeline stage 1 (edge 1):
  - Registers the entry read, pix_valid, and the index-is-zero flag.
  - A lookup and a write to the same entry in the same cycle return the OLD value; the new value is visible from the next request.
- Pipeline stage 2 (edge 2):
  - Each channel out = sat0(c − (LMAX − level)), computed in CHAN_W+1 bits and clamped at 0. Level is sampled at stage 2.
  - out_valid = stage-1 valid.
  - When out_valid = 0, RGB holds its previous value.
  - Fully pipelined: one lookup per cycle, no stalls.
- Fade FSM:
  - States: IDLE, FADE_OUT, FADE_IN.
  - IDLE + fade_start: go to FADE_OUT if fade_dir = 0, else FADE_IN. Divider is cleared.
  - fade_start while busy: ignored.
  - In a FADE state, the divider counts 0..FADE_DIV-1. On wrap, level decrements (OUT) or increments (IN).
  - When level reaches 0 (OUT) or LMAX (IN), return to IDLE on that same edge.
  - Start while already at target level: one cycle in the FADE state, level unchanged, then IDLE.
  - fade_busy = (state != IDLE).
  - Full fade duration = LMAX*FADE_DIV cycles after the start edge.
- fade_level = level register.

Optional Feature:
- Macro: SPRITE_PALETTE_TRANSPARENT_KEY_EN.
- Defined:
  - Index 0 of every palette is the transparent key.
  - out_transparent = 1 with out_valid when the request had pix_index = 0. RGB still shows the stored entry, faded.
  - Writes to index 0 are accepted and stored.
- Undefined: out_transparent is tied to 0, and no index-zero flag flop is generated.

Test Plan (INDEX_W=4, CHAN_W=4, NUM_PAL=4, FADE_DIV=2):
- Reset, then lookup pal 2 idx 5 → out_valid 2 cycles later, RGB = 0,0,0; fade_level = 15; wr_ready = 1.
- Write pal 1 idx 3 = 0xB74, then lookup it every cycle for 4 cycles → each result valid at +2 cycles, RGB = B,7,4, back-to-back.
- Same-cycle write pal 0 idx 7 = 0xFFF and lookup pal 0 idx 7 (old 0x000) → first result 0,0,0; next lookup gives F,F,F.
- With entry 0xE94, fade_start dir = 0 → fade_busy = 1 for 30 cycles; wr_ready = 0 meanwhile. After 4 steps (level 11) the lookup returns A,5,0. At level 0 the output is 0,0,0. A write attempted mid-fade is not accepted and contents are unchanged.
- fade_start while busy → ignored. Then fade_start dir = 1 at level 15 → busy exactly 1 cycle, level stays 15.
- With macro defined, lookup idx 0 and idx 1 → out_transparent = 1 then 0, aligned with out_valid. Assert Reset_n mid-pipeline → out_valid = 0 immediately.
